lz77_decode_sched: RTL
======================

Name: lz77_decode_sched

Overview:
- Sequencer sitting between the code-word source (ROM/FIFO reader) and LZ77_Decoder.
- Pops one (pos, len, char) code word per handshake and holds it stable on the decoder inputs for exactly len+1 issue cycles.
- Qualifies the decoder's char_nxt into a valid-strobed output stream and detects the '$' end marker.
- Waits for decoder finish, then reports done, character count and sticky error.

Parameters:
- SEARCH_BUF, 9, search-buffer depth; legal code_pos range is 0..SEARCH_BUF-1 when len!=0.
- DEC_LAT, 1, cycles from a code word being applied to the decoder until its first char_nxt is valid (1..4).
- CNT_W, 16, width of the emitted-character counter.
- FIN_TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cw_valid  in  1  code word available.
- cw_ready  out  1  scheduler accepts the code word this cycle.
- cw_pos  in  4  match position.
- cw_len  in  3  match length.
- cw_char  in  8  literal/next character.
- code_pos  out  4  to decoder.
- code_len  out  3  to decoder.
- chardata  out  8  to decoder.
- dec_encode  in  1  decoder encode flag; must be low while decoding.
- dec_finish  in  1  decoder finish.
- dec_char_nxt  in  8  decoder output character.
- out_valid  out  1  out_char is valid this cycle.
- out_char  out  8  decoded character.
- char_cnt  out  CNT_W  number of characters emitted.
- done  out  1  sticky; decode complete.
- err  out  1  sticky; protocol error.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0, except cw_ready=0 until the first clock after release.
- Handshake: a code word transfers on a clock edge with cw_valid&&cw_ready. Upstream holds cw_* stable while cw_valid is high and cw_ready is low.
- State IDLE
  - cw_ready=1.
  - On transfer: latch into code_pos/code_len/chardata, set rem=cw_len, go to ISSUE.
  - Exception: a pure terminator (cw_char=8'h24, pos=0, len=0) emits nothing and goes straight to WAIT_FIN.
- State ISSUE (one issue strobe per cycle)
  - rem decrements each cycle.
  - On the last issue cycle (rem==0):
    - if the latched chardata==8'h24, go to WAIT_FIN;
    - otherwise cw_ready=1, so a back-to-back next word is latched with no bubble; if cw_valid=0, go to IDLE.
  - Decoder inputs change only on transfer edges.
- Output path
  - Issue strobes pass through a DEC_LAT-deep shift register; out_valid equals the delayed strobe.
  - out_char=dec_char_nxt, passed through combinationally when out_valid=1, else 0.
  - char_cnt increments on each out_valid and saturates at all-ones.
- State WAIT_FIN
  - cw_ready=0.
  - Drain any pending strobes.
  - Go to DONE on the first dec_finish=1 after the shift register is empty.
- State DONE: done=1 and cw_ready=0 until reset. Extra cw_valid is ignored.
- Errors (err sets and stays set until reset; processing continues):
  - cw_pos>=SEARCH_BUF with cw_len!=0: word is consumed but not issued; counts as zero emissions.
  - dec_encode=1 while out_valid=1: that character is still emitted.
  - dec_finish=1 in IDLE or ISSUE before the end marker.
- Simultaneous events: a dec_finish arriving in the same cycle as the last delayed strobe is accepted; that character is emitted and the transition to DONE happens at the same edge.
- Mid-operation reset: immediate return to the reset state; any partially issued word is lost.

Optional Feature:
- Macro: LZ77_SCHED_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles in WAIT_FIN after the strobes have drained. Reaching FIN_TIMEOUT without dec_finish sets err, forces DONE and asserts done.
- Undefined: no watchdog; WAIT_FIN waits indefinitely.

Decomposition:
- Package lz77_pkg:
  - state enum (IDLE, ISSUE, WAIT_FIN, DONE);
  - END_MARK=8'h24;
  - POS_W=4, LEN_W=3, CHAR_W=8;
  - packed struct code_word_t {pos, len, char}.
- Sub-module lz77_strobe_delay: the DEC_LAT shift register for issue strobes.
- FSM, counters and error logic stay in the top module.

Test Plan:
- Single literal (pos 0, len 0, char 8'h3) then terminator (0, 0, 8'h24) with dec_finish asserted:
  - exactly 1 out_valid, out_char=8'h3;
  - char_cnt=1, done=1, err=0.
- Word (pos 2, len 3, char 8'h5) back-to-back with (0, 1, 8'h7), cw_valid held high:
  - cw_ready pulses with no bubble;
  - 4+2=6 consecutive out_valid cycles;
  - char_cnt=6.
- Final word (1, 2, 8'h24):
  - 3 emissions, the last with out_char=8'h24 (decoder model returns '$');
  - enters WAIT_FIN and ignores further cw_valid;
  - done after dec_finish.
- Word with cw_pos=10, len=2 (SEARCH_BUF=9):
  - err=1, zero emissions from that word;
  - the following valid word still decodes correctly.
- dec_encode forced high during ISSUE: err=1; char_cnt still increments.
- Terminator with dec_finish held low for 100 cycles:
  - with LZ77_SCHED_TIMEOUT_EN: done=1 and err=1 at 64 cycles after drain;
  - without it: done stays 0.
- Async reset mid-ISSUE: all outputs 0 immediately; after release, a fresh word decodes normally.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 decode scheduler.
package lz77_pkg;

  localparam int unsigned POS_W  = 4;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CHAR_W = 8;

  localparam logic [CHAR_W-1:0] END_MARK = 8'h24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_FIN = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [LEN_W-1:0]  len;
    logic [CHAR_W-1:0] ch;
  } code_word_t;

  // A bare end marker carries no characters and goes straight to the finish wait.
  function automatic logic is_terminator(input code_word_t w);
    return (w.ch == END_MARK) && (w.pos == 4'd0) && (w.len == 3'd0);
  endfunction

endpackage

// File: rtl/lz77_strobe_delay.sv
// Delays issue strobes by the decoder latency; flags strobes still in flight.
module lz77_strobe_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic valid,
  output logic pending
);

  // Every stage except the output one; those strobes have not reached out_valid yet.
  localparam logic [DEPTH-1:0] HEAD_MASK = ~(DEPTH'(1) << (DEPTH - 1));

  logic [DEPTH-1:0] sr;

  // Shift register, newest strobe enters at bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(strobe);
    end
  end

  assign valid   = sr[DEPTH-1];
  assign pending = |(sr & HEAD_MASK);

endmodule

// File: rtl/lz77_decode_sched.sv
// Code-word sequencer in front of LZ77_Decoder: issues each word len+1 cycles,
// qualifies decoder output, reports done/count/error. Optional: LZ77_SCHED_TIMEOUT_EN.
module lz77_decode_sched
  import lz77_pkg::*;
#(
  parameter int unsigned SEARCH_BUF  = 9,
  parameter int unsigned DEC_LAT     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FIN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [3:0]       cw_pos,
  input  logic [2:0]       cw_len,
  input  logic [7:0]       cw_char,
  output logic [3:0]       code_pos,
  output logic [2:0]       code_len,
  output logic [7:0]       chardata,
  input  logic             dec_encode,
  input  logic             dec_finish,
  input  logic [7:0]       dec_char_nxt,
  output logic             out_valid,
  output logic [7:0]       out_char,
  output logic [CNT_W-1:0] char_cnt,
  output logic             done,
  output logic             err
);

  if (DEC_LAT < 1 || DEC_LAT > 4) begin : g_bad_dec_lat
    $error("DEC_LAT must be 1..4");
  end
  if (FIN_TIMEOUT < 1 || FIN_TIMEOUT > 255) begin : g_bad_fin_timeout
    $error("FIN_TIMEOUT must fit the 8-bit watchdog");
  end

  state_t           state_r, state_n;
  code_word_t       word_r;
  code_word_t       in_word_s;
  logic [LEN_W-1:0] rem_r, rem_n;
  logic             ready_en_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r, err_r;
  logic             cw_ready_s, issue_s, accept_s, timeout_s;
  logic             bad_s, term_s, pending_s, err_set_s, wd_hit_s;

  assign in_word_s = '{pos: cw_pos, len: cw_len, ch: cw_char};
  assign bad_s     = (cw_len != 3'd0) && (32'(cw_pos) >= SEARCH_BUF);
  assign term_s    = is_terminator(in_word_s);

  lz77_strobe_delay #(.DEPTH(DEC_LAT)) u_delay (
    .clk     (clk),
    .reset   (reset),
    .strobe  (issue_s),
    .valid   (out_valid),
    .pending (pending_s)
  );

`ifdef LZ77_SCHED_TIMEOUT_EN
  logic [7:0] wd_r;
  logic       wd_run_s;

  assign wd_run_s = (state_r == WAIT_FIN) && !pending_s && !out_valid && !dec_finish;
  assign wd_hit_s = wd_run_s && (wd_r == 8'(FIN_TIMEOUT - 1));

  // Watchdog: counts drained cycles spent waiting for the decoder to finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= 8'd0;
    end else if (wd_run_s) begin
      wd_r <= wd_r + 8'd1;
    end else begin
      wd_r <= wd_r;
    end
  end
`else
  assign wd_hit_s = 1'b0;
`endif

  // Next-state, handshake and issue strobe decode.
  always_comb begin
    state_n    = state_r;
    rem_n      = rem_r;
    cw_ready_s = 1'b0;
    issue_s    = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: cw_ready_s = ready_en_r;
      ISSUE: begin
        issue_s = 1'b1;
        if (rem_r != 3'd0) begin
          rem_n = rem_r - 3'd1;
        end else if (word_r.ch == END_MARK) begin
          state_n = WAIT_FIN;
        end else begin
          cw_ready_s = 1'b1;
          state_n    = IDLE;
        end
      end
      WAIT_FIN: begin
        // A finish coinciding with the last delayed strobe is accepted.
        if (!pending_s && dec_finish) begin
          state_n = DONE;
        end else if (wd_hit_s) begin
          state_n   = DONE;
          timeout_s = 1'b1;
        end else begin
          state_n = WAIT_FIN;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    accept_s = cw_valid && cw_ready_s;
    if (accept_s) begin
      rem_n = cw_len;
      if (bad_s) begin
        state_n = IDLE;
      end else if (term_s) begin
        state_n = WAIT_FIN;
      end else begin
        state_n = ISSUE;
      end
    end else begin
      rem_n = rem_n;
    end
  end

  assign err_set_s = (accept_s && bad_s) ||
                     (dec_encode && out_valid) ||
                     (dec_finish && ((state_r == IDLE) || (state_r == ISSUE))) ||
                     timeout_s;

  // State, latched code word, counters and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      word_r     <= '0;
      rem_r      <= 3'd0;
      ready_en_r <= 1'b0;
      cnt_r      <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      rem_r      <= rem_n;
      ready_en_r <= 1'b1;
      if (accept_s && !bad_s) begin
        word_r <= in_word_s;
      end else begin
        word_r <= word_r;
      end
      if (out_valid && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      done_r <= done_r | (state_n == DONE);
      err_r  <= err_r | err_set_s;
    end
  end

  assign cw_ready = cw_ready_s;
  assign code_pos = word_r.pos;
  assign code_len = word_r.len;
  assign chardata = word_r.ch;
  assign out_char = out_valid ? dec_char_nxt : 8'h00;
  assign char_cnt = cnt_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule
